// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code step decoder: default width, FSM encoding,
// step direction codes and the error-count saturation value.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } dec_state_e;

  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;
  localparam logic [7:0] ERR_SAT  = 8'd255;

endpackage

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of the Gray bits
// at and above its own position.
module gray_to_binary #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Synchronises an asynchronous Gray count, converts it to binary and turns each change
// into an up/down step event or an illegal-jump error, with position and error counters.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int GRAY_W      = GRAY_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [GRAY_W-1:0]       gray_in,
  input  logic                    clear_pos,
  output logic [GRAY_W-1:0]       bin_out,
  output logic                    step_valid,
  output logic                    step_dir,
  output logic                    step_err,
  output logic signed [POS_W-1:0] position,
  output logic [7:0]              err_count,
  output logic                    primed
);

  localparam logic [GRAY_W-1:0] GRAY_ONE  = {{(GRAY_W-1){1'b0}}, 1'b1};
  localparam logic [POS_W-1:0]  POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        FILL_LAST = 2'(SYNC_STAGES - 1);

  dec_state_e                         state_q, state_d;
  logic [1:0]                         fill_q, fill_d;
  logic [SYNC_STAGES-1:0][GRAY_W-1:0] sync_q, sync_d;
  logic [GRAY_W-1:0]                  prev_gray_q, prev_gray_d;
  logic [GRAY_W-1:0]                  bin_out_q, bin_out_d;
  logic                               step_valid_q, step_valid_d;
  logic                               step_dir_q, step_dir_d;
  logic                               step_err_q, step_err_d;
  logic                               primed_q, primed_d;
  logic [POS_W-1:0]                   position_q, position_d;
  logic [7:0]                         err_count_q, err_count_d;

  logic [GRAY_W-1:0] sync_out, bin_new, bin_old, bin_old_inc, bin_old_dec;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign bin_old_inc = bin_old + GRAY_ONE;
  assign bin_old_dec = bin_old - GRAY_ONE;

  gray_to_binary #(.W(GRAY_W)) u_g2b_new (.gray_i(sync_out),    .bin_o(bin_new));
  gray_to_binary #(.W(GRAY_W)) u_g2b_old (.gray_i(prev_gray_q), .bin_o(bin_old));

  // Next-state logic: synchroniser shift, FSM, step classifier and accumulators.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    sync_d       = sync_q;
    prev_gray_d  = prev_gray_q;
    bin_out_d    = bin_out_q;
    step_valid_d = 1'b0;
    step_dir_d   = step_dir_q;
    step_err_d   = 1'b0;
    primed_d     = primed_q;
    position_d   = position_q;
    err_count_d  = err_count_q;

    if (enable) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], gray_in};
      case (state_q)
        FILL: begin
          if (fill_q == FILL_LAST) begin
            fill_d  = 2'd0;
            state_d = PRIME;
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end
        PRIME: begin
          prev_gray_d = sync_out;
          bin_out_d   = bin_new;
          primed_d    = 1'b1;
          state_d     = RUN;
        end
        RUN: begin
          // Adjacent binary values always differ in exactly one Gray bit, so the
          // +-1 comparison alone separates legal steps from illegal jumps.
          if (sync_out != prev_gray_q) begin
            prev_gray_d = sync_out;
            bin_out_d   = bin_new;
            if (bin_new == bin_old_inc) begin
              step_valid_d = 1'b1;
              step_dir_d   = DIR_UP;
              position_d   = position_q + POS_ONE;
            end else if (bin_new == bin_old_dec) begin
              step_valid_d = 1'b1;
              step_dir_d   = DIR_DOWN;
              position_d   = position_q - POS_ONE;
            end else begin
              step_err_d = 1'b1;
              if (err_count_q != ERR_SAT) begin
                err_count_d = err_count_q + 8'd1;
              end else begin
                err_count_d = err_count_q;
              end
            end
          end else begin
            prev_gray_d = prev_gray_q;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = 2'd0;
        end
      endcase
      if (clear_pos) begin
        position_d = '0;
      end else begin
        position_d = position_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FILL;
      fill_q       <= 2'd0;
      sync_q       <= '0;
      prev_gray_q  <= '0;
      bin_out_q    <= '0;
      step_valid_q <= 1'b0;
      step_dir_q   <= 1'b0;
      step_err_q   <= 1'b0;
      primed_q     <= 1'b0;
      position_q   <= '0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      sync_q       <= sync_d;
      prev_gray_q  <= prev_gray_d;
      bin_out_q    <= bin_out_d;
      step_valid_q <= step_valid_d;
      step_dir_q   <= step_dir_d;
      step_err_q   <= step_err_d;
      primed_q     <= primed_d;
      position_q   <= position_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bin_out    = bin_out_q;
  assign step_valid = step_valid_q;
  assign step_dir   = step_dir_q;
  assign step_err   = step_err_q;
  assign position   = position_q;
  assign err_count  = err_count_q;
  assign primed     = primed_q;

endmodule
